// File: rtl/digit_scan_pkg.sv
// Shared types and constants for the multiplexed 7-segment digit scanner.
package digit_scan_pkg;

    // Select width is fixed by the 8:1 digit mux downstream.
    localparam int unsigned SEL_W      = 3;
    localparam int unsigned MAX_DIGITS = 8;

    typedef enum logic [1:0] {
        OFF,
        BLANK,
        SHOW
    } scan_state_t;

endpackage

// File: rtl/tick_gen.sv
// Digit-slot prescaler: counts 0..DIV_COUNT-1 while enabled, holds while disabled,
// and emits a registered one-cycle tick on the edge where the count wraps.
module tick_gen #(
    parameter int unsigned DIV_COUNT = 100_000,
    localparam int unsigned CNT_W    = $clog2(DIV_COUNT + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    output logic             tick,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV_COUNT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q;
    logic             wrap;

    // Next prescaler value; frozen when scanning is disabled.
    always_comb begin
        wrap  = enable && (cnt_q == LAST);
        cnt_d = cnt_q;
        if (enable) begin
            cnt_d = wrap ? '0 : cnt_q + 1'b1;
        end
    end

    // Prescaler and tick registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= wrap;
        end
    end

    assign tick = tick_q;
    assign cnt  = cnt_q;

endmodule

// File: rtl/digit_scan_ctrl.sv
// Round-robin scan controller for an 8-digit multiplexed 7-segment display.
// Drives the digit select for the downstream mux and the matching active-low anodes,
// both registered on the same edge so a digit is never lit with a stale select.
// Optional macro DIGIT_SCAN_GHOST_BLANK_EN adds an anode-off window at the start of
// every slot (BLANK state) to hide mux/decoder settling.
module digit_scan_ctrl
    import digit_scan_pkg::*;
#(
    parameter int unsigned DIV_COUNT    = 100_000,
    parameter int unsigned N_DIGITS     = 8,
    parameter int unsigned BLANK_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [MAX_DIGITS-1:0] digit_en,
    output logic [SEL_W-1:0]      sel,
    output logic [MAX_DIGITS-1:0] anodes,
    output logic                  tick
);

    localparam int unsigned CNT_W = $clog2(DIV_COUNT + 1);
    localparam logic [CNT_W-1:0] LAST     = CNT_W'(DIV_COUNT - 1);
    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(N_DIGITS - 1);

    // Elaboration-time legality checks on the configuration.
    if (DIV_COUNT < 1 || DIV_COUNT > (1 << 20)) begin : g_bad_div
        $error("digit_scan_ctrl: DIV_COUNT out of range");
    end
    if (N_DIGITS < 1 || N_DIGITS > MAX_DIGITS) begin : g_bad_ndig
        $error("digit_scan_ctrl: N_DIGITS out of range");
    end
    if (BLANK_CYCLES >= DIV_COUNT) begin : g_bad_blank
        $error("digit_scan_ctrl: BLANK_CYCLES must be below DIV_COUNT");
    end

    logic [CNT_W-1:0]      cnt;
    logic                  wrap;
    scan_state_t           state_q, state_d;
    logic [SEL_W-1:0]      sel_q, sel_d;
    logic [MAX_DIGITS-1:0] anodes_q, anodes_d;

    tick_gen #(
        .DIV_COUNT (DIV_COUNT)
    ) u_tick_gen (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .tick   (tick),
        .cnt    (cnt)
    );

    // Same terminal-count condition the prescaler uses; enable low suppresses it.
    assign wrap = enable && (cnt == LAST);

`ifdef DIGIT_SCAN_GHOST_BLANK_EN
    logic [CNT_W-1:0] cnt_nxt;
    logic             blank_done;

    // Blanking ends once the prescaler value for the next cycle reaches BLANK_CYCLES.
    always_comb begin
        cnt_nxt    = wrap ? '0 : cnt + 1'b1;
        blank_done = (cnt_nxt >= CNT_W'(BLANK_CYCLES));
    end
`endif

    // Next state, next select and the anode pattern that goes with them.
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        anodes_d = '1;

        if (!enable) begin
            state_d = OFF;
        end else begin
            if (wrap) begin
                sel_d = (sel_q == LAST_SEL) ? '0 : sel_q + 1'b1;
            end
`ifdef DIGIT_SCAN_GHOST_BLANK_EN
            if (wrap || state_q != SHOW) begin
                state_d = blank_done ? SHOW : BLANK;
            end
`else
            state_d = SHOW;
`endif
        end

        // Digits at or above N_DIGITS are never lit.
        if (state_d == SHOW) begin
            for (int i = 0; i < int'(N_DIGITS); i++) begin
                if (sel_d == SEL_W'(i) && digit_en[i]) begin
                    anodes_d[i] = 1'b0;
                end
            end
        end
    end

    // State, select and anode registers share one edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= OFF;
            sel_q    <= '0;
            anodes_q <= '1;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            anodes_q <= anodes_d;
        end
    end

    assign sel    = sel_q;
    assign anodes = anodes_q;

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Bench for digit_scan_ctrl: three instances (DIV 4 / 8 digits, DIV 2 / 5 digits,
// DIV 1 / 8 digits) share stimulus. A slot-level model checks every cycle; literal
// expectations along the directed sequence pin the model for the DIV 4 instance.
module tb_digit_scan_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [7:0] digit_en = 8'hFF;

    logic [2:0] sel_a, sel_b, sel_c;
    logic [7:0] an_a, an_b, an_c;
    logic       tick_a, tick_b, tick_c;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    bit          chk_on = 1'b0;

    always #5 clk = ~clk;

    digit_scan_ctrl #(.DIV_COUNT(4), .N_DIGITS(8), .BLANK_CYCLES(3)) u_a (
        .clk(clk), .reset(reset), .enable(enable), .digit_en(digit_en),
        .sel(sel_a), .anodes(an_a), .tick(tick_a)
    );
    digit_scan_ctrl #(.DIV_COUNT(2), .N_DIGITS(5), .BLANK_CYCLES(1)) u_b (
        .clk(clk), .reset(reset), .enable(enable), .digit_en(digit_en),
        .sel(sel_b), .anodes(an_b), .tick(tick_b)
    );
    digit_scan_ctrl #(.DIV_COUNT(1), .N_DIGITS(8), .BLANK_CYCLES(0)) u_c (
        .clk(clk), .reset(reset), .enable(enable), .digit_en(digit_en),
        .sel(sel_c), .anodes(an_c), .tick(tick_c)
    );

    // Model: per instance, slot position, current digit and whether the display is on.
    int unsigned p_div[3] = '{4, 2, 1};
    int unsigned p_nd[3]  = '{8, 5, 8};
    int unsigned p_bc[3]  = '{3, 1, 0};
    int unsigned m_cnt[3];
    int unsigned m_sel[3];
    bit          m_on[3];
    bit          m_blank[3];
    bit          m_tick[3];
    logic [7:0]  m_an[3];

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (reset) begin
                m_cnt[k] = 0; m_sel[k] = 0; m_on[k] = 0; m_blank[k] = 0;
                m_tick[k] = 0; m_an[k] = 8'hFF;
            end else if (!enable) begin
                m_on[k] = 0; m_tick[k] = 0; m_an[k] = 8'hFF;
            end else begin
                bit entering;
                bit wrap;
                entering = !m_on[k];
                m_on[k] = 1;
                wrap = (m_cnt[k] == p_div[k] - 1);
                m_cnt[k] = wrap ? 0 : m_cnt[k] + 1;
                if (wrap) m_sel[k] = (m_sel[k] + 1) % p_nd[k];
                m_tick[k] = wrap;
`ifdef DIGIT_SCAN_GHOST_BLANK_EN
                if (wrap || entering) m_blank[k] = 1;
                if (m_cnt[k] >= p_bc[k]) m_blank[k] = 0;
`else
                if (entering) m_blank[k] = 0;
`endif
                m_an[k] = 8'hFF;
                if (!m_blank[k] && digit_en[m_sel[k]] && m_sel[k] < p_nd[k])
                    m_an[k][m_sel[k]] = 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("model sel_a", 32'(sel_a), m_sel[0]);
            chk("model an_a", 32'(an_a), 32'(m_an[0]));
            chk("model tick_a", 32'(tick_a), 32'(m_tick[0]));
            chk("model sel_b", 32'(sel_b), m_sel[1]);
            chk("model an_b", 32'(an_b), 32'(m_an[1]));
            chk("model tick_b", 32'(tick_b), 32'(m_tick[1]));
            chk("model sel_c", 32'(sel_c), m_sel[2]);
            chk("model an_c", 32'(an_c), 32'(m_an[2]));
            chk("model tick_c", 32'(tick_c), 32'(m_tick[2]));
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic lit_a(input string name, input int s, input logic [7:0] an, input bit t);
        chk({name, " sel_a"}, 32'(sel_a), 32'(s));
        chk({name, " an_a"}, 32'(an_a), 32'(an));
        chk({name, " tick_a"}, 32'(tick_a), 32'(t));
    endtask

    initial begin
        step(2);
        chk_on = 1'b1;
`ifndef DIGIT_SCAN_GHOST_BLANK_EN
        lit_a("reset", 0, 8'hFF, 0);
        chk("reset an_b", 32'(an_b), 32'h FF);
        chk("reset an_c", 32'(an_c), 32'h FF);
`endif
        reset = 1'b0;
        enable = 1'b1;
        step(1);
`ifndef DIGIT_SCAN_GHOST_BLANK_EN
        lit_a("first slot", 0, 8'hFE, 0);
        chk("div1 sel_c", 32'(sel_c), 32'd1);
        chk("div1 tick_c", 32'(tick_c), 32'd1);
        chk("div1 an_c", 32'(an_c), 32'h FD);
`endif
        step(3);
`ifndef DIGIT_SCAN_GHOST_BLANK_EN
        lit_a("first tick", 1, 8'hFD, 1);
        chk("n5 sel_b", 32'(sel_b), 32'd2);
        chk("n5 an_b", 32'(an_b), 32'h FB);
        chk("div1 4 sel_c", 32'(sel_c), 32'd4);
`endif
        step(28);
`ifndef DIGIT_SCAN_GHOST_BLANK_EN
        lit_a("wrap 7to0", 0, 8'hFE, 1);
        chk("n5 wrap sel_b", 32'(sel_b), 32'd1);
        chk("n5 wrap an_b", 32'(an_b), 32'h FD);
`endif
        digit_en = 8'hAA;
        step(1);
`ifndef DIGIT_SCAN_GHOST_BLANK_EN
        lit_a("mask slot0", 0, 8'hFF, 0);
`endif
        step(3);
`ifndef DIGIT_SCAN_GHOST_BLANK_EN
        lit_a("mask slot1", 1, 8'hFD, 1);
`endif
        step(8);
`ifndef DIGIT_SCAN_GHOST_BLANK_EN
        lit_a("mask slot3", 3, 8'hF7, 1);
`endif
        step(2);
`ifndef DIGIT_SCAN_GHOST_BLANK_EN
        lit_a("pre drop", 3, 8'hF7, 0);
`endif
        enable = 1'b0;
        step(1);
`ifndef DIGIT_SCAN_GHOST_BLANK_EN
        lit_a("drop", 3, 8'hFF, 0);
`endif
        step(9);
`ifndef DIGIT_SCAN_GHOST_BLANK_EN
        lit_a("held", 3, 8'hFF, 0);
`endif
        enable = 1'b1;
        step(1);
`ifndef DIGIT_SCAN_GHOST_BLANK_EN
        lit_a("resume", 3, 8'hF7, 0);
`endif
        step(1);
`ifndef DIGIT_SCAN_GHOST_BLANK_EN
        lit_a("resume tick", 4, 8'hFF, 1);
`endif
        step(3);
        enable = 1'b0;
        step(1);
`ifndef DIGIT_SCAN_GHOST_BLANK_EN
        lit_a("drop at tc", 4, 8'hFF, 0);
`endif
        enable = 1'b1;
        step(1);
`ifndef DIGIT_SCAN_GHOST_BLANK_EN
        lit_a("tc resume", 5, 8'hDF, 1);
`endif
        step(4);
`ifndef DIGIT_SCAN_GHOST_BLANK_EN
        lit_a("slot6", 6, 8'hFF, 1);
`endif
        step(1);
        reset = 1'b1;
        step(1);
`ifndef DIGIT_SCAN_GHOST_BLANK_EN
        lit_a("mid reset", 0, 8'hFF, 0);
`endif
        reset = 1'b0;
        digit_en = 8'hFF;
        step(1);
`ifndef DIGIT_SCAN_GHOST_BLANK_EN
        lit_a("restart", 0, 8'hFE, 0);
`endif
        step(3);
`ifndef DIGIT_SCAN_GHOST_BLANK_EN
        lit_a("restart tick", 1, 8'hFD, 1);
`endif
        step(8);
        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/digit_scan_ctrl.md
Name: digit_scan_ctrl

Overview:
Scan controller for the 8-digit multiplexed 7-segment display. It generates the 3-bit digit select that drives the 8:1 4-bit digit mux directly downstream. It also produces the matching active-low anode vector for the digit currently shown. Digits are refreshed round-robin at a rate set by an internal prescaler.

Parameters:
DIV_COUNT, 100_000, clk cycles per digit slot (1 kHz digit rate at 100 MHz); legal range 1..2^20.
N_DIGITS, 8, number of digits scanned; legal range 1..8.
SEL_W, 3, select width; fixed to match the downstream mux.
BLANK_CYCLES, 16, anode-off cycles at the start of each slot (used only with the optional feature); must be < DIV_COUNT.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
enable  input  1  1 = scanning runs; 0 = display off, counters frozen
digit_en  input  8  per-digit light mask; bit i = 1 lets digit i light
sel  output  SEL_W  digit index to the downstream mux, registered
anodes  output  8  active-low anode drive, registered; bit i low = digit i lit
tick  output  1  one-cycle pulse on the cycle sel advances

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset.
- Reset values: prescaler = 0, sel = 0, anodes = 8'hFF, tick = 0, FSM = OFF. Reset has priority over everything, including mid-slot.
- Prescaler: counts 0..DIV_COUNT-1 while enable = 1. On the clk edge where the count is DIV_COUNT-1:
  - the count wraps to 0;
  - sel <= (sel == N_DIGITS-1) ? 0 : sel+1;
  - tick = 1 for exactly that following cycle.
- DIV_COUNT = 1: tick is high every cycle and sel advances every cycle.
- FSM states and transitions:
  - OFF: anodes = FF. Moves to SHOW (or BLANK, with the feature) on the first enable = 1 cycle.
  - SHOW: anodes[i] = ~(i == sel && digit_en[i]). Bits i >= N_DIGITS are always 1.
  - Any state goes to OFF when enable = 0. In OFF the prescaler and sel hold their values; they do not clear.
  - Re-enable resumes from the held sel and prescaler values.
- Alignment: sel and anodes are registered on the same edge, so anodes never light a digit with a stale sel.
- Latency: a digit_en change is reflected in anodes one cycle later. A deassert of enable blanks anodes one cycle later.
- Simultaneous events: if enable drops on the same cycle the prescaler hits terminal count, enable wins. No advance and no tick occur.
- Width rules: the prescaler is $clog2(DIV_COUNT+1) bits. sel comparisons are done at SEL_W bits.

Optional Feature:
Macro: DIGIT_SCAN_GHOST_BLANK_EN
- Defined: adds a BLANK state. Each tick, and each OFF->active transition, enters BLANK.
  - In BLANK, anodes = FF for BLANK_CYCLES cycles, counted on the prescaler value. The FSM moves to SHOW when the prescaler reaches BLANK_CYCLES.
  - Purpose: suppress ghosting while the downstream mux and decoder settle.
- Not defined: BLANK does not exist. The FSM goes straight to SHOW, and the BLANK_CYCLES parameter is ignored.

Decomposition:
Package digit_scan_pkg holds:
- the typedef enum scan_state_t {OFF, BLANK, SHOW};
- the constants SEL_W = 3 and MAX_DIGITS = 8.
One sub-module: tick_gen (parameter DIV_COUNT; inputs clk, reset, enable; outputs tick and cnt). digit_scan_ctrl instantiates it and uses cnt for BLANK timing.

Test Plan:
1. DIV_COUNT=4, N_DIGITS=8, enable=1, digit_en=FF. Expected: sel steps 0,1,...,7,0 every 4 cycles; anodes FE, FD, FB, ..., 7F; tick pulses every 4th cycle.
2. N_DIGITS=5, DIV_COUNT=2. Expected: sel wraps 4->0; anodes[7:5] stay 1 throughout; sel never reaches 5.
3. digit_en=8'b1010_1010 with a full scan. Expected: anodes = FF during slots 0, 2, 4, 6; FD during slot 1, F7 during slot 3, and so on.
4. enable=0 at sel=3 with prescaler=2, held 10 cycles, then re-enabled. Expected: anodes = FF one cycle after the drop; sel stays 3 while disabled; the next tick arrives 2 cycles after re-enable.
5. reset pulsed mid-slot at sel=6. Expected: next cycle sel=0, anodes=FF, tick=0; scanning then restarts from digit 0.
6. With DIGIT_SCAN_GHOST_BLANK_EN, DIV_COUNT=8, BLANK_CYCLES=3. Expected: in each slot anodes = FF for 3 cycles, then the digit is lit for 5 cycles.
